// File: rtl/inst_fetch_if.sv
// Instruction fetch bus: push side toward the instruction queue and the
// word-fetch handshake toward the memory controller.
interface inst_fetch_if;
    logic        IQ_nxt_full;
    logic        IF_S;
    logic [31:0] IF_Inst;
    logic [31:0] IF_pc;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_done;
    logic [31:0] MC_data;

    modport master (
        input  IQ_nxt_full,
        input  MC_done,
        input  MC_data,
        output IF_S,
        output IF_Inst,
        output IF_pc,
        output MC_req,
        output MC_addr
    );

    modport slave (
        output IQ_nxt_full,
        output MC_done,
        output MC_data,
        input  IF_S,
        input  IF_Inst,
        input  IF_pc,
        input  MC_req,
        input  MC_addr
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage with a direct-mapped icache; misses are serviced by
// a single outstanding word request to the memory controller.
module inst_fetch #(
    parameter int          ICACHE_IDX = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic [31:0] clr_pc,
    inst_fetch_if.master bus
);

    localparam int          ENTRIES  = 1 << ICACHE_IDX;
    localparam int          TAG_W    = 30 - ICACHE_IDX;
    localparam logic [31:0] WORD_MSK = ~32'h3;
    localparam logic [31:0] PC_INIT  = RESET_PC & WORD_MSK;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state, state_nxt;

    logic [31:0] pc, pc_nxt, pc_inc;
    logic        if_s, if_s_nxt;
    logic [31:0] if_inst, if_inst_nxt;
    logic [31:0] if_pc, if_pc_nxt;
    logic        mc_req, mc_req_nxt;
    logic [31:0] mc_addr, mc_addr_nxt;

    logic [31:0]           cache_data [ENTRIES];
    logic [TAG_W-1:0]      cache_tag  [ENTRIES];
    logic [ENTRIES-1:0]    cache_valid;

    logic [ICACHE_IDX-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic                  fill_en;

    assign idx    = pc[ICACHE_IDX+1:2];
    assign tag    = pc[31:ICACHE_IDX+2];
    assign hit    = cache_valid[idx] && (cache_tag[idx] == tag);
    assign pc_inc = (pc + 32'd4) & WORD_MSK;

    // While waiting, pc still holds the miss address, so fills index with pc.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        if_s_nxt    = 1'b0;
        if_inst_nxt = if_inst;
        if_pc_nxt   = if_pc;
        mc_req_nxt  = mc_req;
        mc_addr_nxt = mc_addr;
        fill_en     = 1'b0;

        if (rdy) begin
            if (clr) begin
                pc_nxt     = clr_pc & WORD_MSK;
                mc_req_nxt = 1'b0;
                state_nxt  = IDLE;
                fill_en    = (state == WAIT) && bus.MC_done;
            end else begin
                unique case (state)
                    IDLE: begin
                        mc_req_nxt = 1'b0;
                        if (!bus.IQ_nxt_full && !if_s) begin
                            if (hit) begin
                                if_s_nxt    = 1'b1;
                                if_inst_nxt = cache_data[idx];
                                if_pc_nxt   = pc;
                                pc_nxt      = pc_inc;
                            end else begin
                                mc_req_nxt  = 1'b1;
                                mc_addr_nxt = pc;
                                state_nxt   = WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (bus.MC_done) begin
                            fill_en     = 1'b1;
                            if_s_nxt    = 1'b1;
                            if_inst_nxt = bus.MC_data;
                            if_pc_nxt   = pc;
                            mc_req_nxt  = 1'b0;
                            pc_nxt      = pc_inc;
                            state_nxt   = IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= PC_INIT;
            if_s    <= 1'b0;
            if_inst <= 32'h0;
            if_pc   <= 32'h0;
            mc_req  <= 1'b0;
            mc_addr <= 32'h0;
        end else begin
            pc      <= pc_nxt;
            if_s    <= if_s_nxt;
            if_inst <= if_inst_nxt;
            if_pc   <= if_pc_nxt;
            mc_req  <= mc_req_nxt;
            mc_addr <= mc_addr_nxt;
        end
    end

    // Only the valid bits need reset; data and tags are don't-care until valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid <= '0;
        end else if (fill_en) begin
            cache_valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            cache_data[idx] <= bus.MC_data;
            cache_tag[idx]  <= tag;
        end
    end

    assign bus.IF_S    = if_s;
    assign bus.IF_Inst = if_inst;
    assign bus.IF_pc   = if_pc;
    assign bus.MC_req  = mc_req;
    assign bus.MC_addr = mc_addr;

endmodule
